// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcodes, instruction field slices and decode helper for the ALU issue/writeback slice.
package alu_pkg;
  localparam int WIDTH = 4;
  localparam int NREG = 4;
  localparam int AW = $clog2(NREG);
  localparam int CNT_W = 8;
  localparam int IW = 9;
  localparam logic [2:0] OP_SUB = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_OR = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_RSHIFT = 3'd4;
  localparam logic [2:0] OP_LSHIFT = 3'd5;
  localparam logic [2:0] OP_LT = 3'd6;
  localparam logic [2:0] OP_EQ = 3'd7;
  localparam int OP_HI = 8;
  localparam int OP_LO = 6;
  localparam int DST_HI = 5;
  localparam int DST_LO = 4;
  localparam int SRCS_HI = 3;
  localparam int SRCS_LO = 2;
  localparam int SRCT_HI = 1;
  localparam int SRCT_LO = 0;
  typedef struct packed {
    logic [2:0] op;
    logic [AW-1:0] dst;
    logic [AW-1:0] src_s;
    logic [AW-1:0] src_t;
  } instr_t;
  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} ex_state_t;
  function automatic instr_t decode(input logic [IW-1:0] i);
    decode.op = i[OP_HI:OP_LO];
    decode.dst = i[DST_HI:DST_LO];
    decode.src_s = i[SRCS_HI:SRCS_LO];
    decode.src_t = i[SRCT_HI:SRCT_LO];
  endfunction
endpackage

// File: rtl/alu_issue_writeback_if.sv
// alu_issue_writeback_if: instruction handshake, external ALU operand/result bus and writeback report.
interface alu_issue_writeback_if;
  import alu_pkg::*;
  logic instr_valid;
  logic instr_ready;
  logic [IW-1:0] instr;
  logic [WIDTH-1:0] alu_rs;
  logic [WIDTH-1:0] alu_rt;
  logic [2:0] alu_sel;
  logic [WIDTH-1:0] alu_rd;
  logic wb_valid;
  logic [AW-1:0] wb_addr;
  logic [WIDTH-1:0] wb_data;
  modport master (output instr_valid, instr, alu_rd, input instr_ready, alu_rs, alu_rt, alu_sel, wb_valid, wb_addr, wb_data);
  modport slave (input instr_valid, instr, alu_rd, output instr_ready, alu_rs, alu_rt, alu_sel, wb_valid, wb_addr, wb_data);
endinterface

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x WIDTH register file, two async operand reads, async debug read, one sync write, async reset.
module alu_regfile
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    ra_s,
  input  logic [AW-1:0]    ra_t,
  input  logic [AW-1:0]    ra_dbg,
  output logic [WIDTH-1:0] rd_s,
  output logic [WIDTH-1:0] rd_t,
  output logic [WIDTH-1:0] rd_dbg
);
  logic [NREG-1:0][WIDTH-1:0] regs_q, regs_d;
  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else regs_q <= regs_d;
  end
  assign rd_s = regs_q[ra_s];
  assign rd_t = regs_q[ra_t];
  assign rd_dbg = regs_q[ra_dbg];
endmodule

// File: rtl/alu_issue_writeback.sv
// alu_issue_writeback: ISSUE -> EXEC/WB pipe around an external combinational ALU.
// Define ALU_FORWARD_EN to bypass alu_rd into RAW-hazard operands instead of stalling one cycle.
module alu_issue_writeback
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  alu_issue_writeback_if.slave bus,
  output logic [CNT_W-1:0]     retired,
  input  logic [AW-1:0]        dbg_addr,
  output logic [WIDTH-1:0]     dbg_data
);
  instr_t in_i;
  ex_state_t ex_state_q, ex_state_d;
  logic [WIDTH-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, wb_data_q, wb_data_d, rd_s, rd_t, op_s, op_t;
  logic [2:0] ex_sel_q, ex_sel_d;
  logic [AW-1:0] ex_dst_q, ex_dst_d, wb_addr_q, wb_addr_d;
  logic wb_valid_q, wb_valid_d, ex_valid, haz_s, haz_t, accept;
  logic [CNT_W-1:0] retired_q, retired_d;
  assign in_i = decode(bus.instr);
  assign ex_valid = ex_state_q == EXEC;
  assign haz_s = ex_valid & (in_i.src_s == ex_dst_q);
  assign haz_t = ex_valid & (in_i.src_t == ex_dst_q);
`ifdef ALU_FORWARD_EN
  assign bus.instr_ready = 1'b1;
  assign op_s = haz_s ? bus.alu_rd : rd_s;
  assign op_t = haz_t ? bus.alu_rd : rd_t;
`else
  assign bus.instr_ready = ~(haz_s | haz_t);
  assign op_s = rd_s;
  assign op_t = rd_t;
`endif
  assign accept = bus.instr_valid & bus.instr_ready;
  alu_regfile u_rf (
    .clk(clk), .rst_n(rst_n), .we(ex_valid), .waddr(ex_dst_q), .wdata(bus.alu_rd),
    .ra_s(in_i.src_s), .ra_t(in_i.src_t), .ra_dbg(dbg_addr),
    .rd_s(rd_s), .rd_t(rd_t), .rd_dbg(dbg_data)
  );
  always_comb begin
    ex_state_d = accept ? EXEC : IDLE;
    ex_rs_d = accept ? op_s : ex_rs_q;
    ex_rt_d = accept ? op_t : ex_rt_q;
    ex_sel_d = accept ? in_i.op : ex_sel_q;
    ex_dst_d = accept ? in_i.dst : ex_dst_q;
    wb_valid_d = ex_valid;
    wb_addr_d = ex_valid ? ex_dst_q : wb_addr_q;
    wb_data_d = ex_valid ? bus.alu_rd : wb_data_q;
    retired_d = retired_q + CNT_W'(ex_valid);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_state_q <= IDLE;
      ex_rs_q <= '0;
      ex_rt_q <= '0;
      ex_sel_q <= '0;
      ex_dst_q <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      retired_q <= '0;
    end else begin
      ex_state_q <= ex_state_d;
      ex_rs_q <= ex_rs_d;
      ex_rt_q <= ex_rt_d;
      ex_sel_q <= ex_sel_d;
      ex_dst_q <= ex_dst_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      retired_q <= retired_d;
    end
  end
  assign bus.alu_rs = ex_rs_q;
  assign bus.alu_rt = ex_rt_q;
  assign bus.alu_sel = ex_sel_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = wb_data_q;
  assign retired = retired_q;
endmodule
